// File: rtl/cv32e40s_obi_mem_responder.sv
// cv32e40s_obi_mem_responder: OBI subordinate backed by a small word memory,
// answering in order after a fixed latency with bus errors for bad addresses.
module cv32e40s_obi_mem_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int MEM_WORDS = 64,
    parameter int MAX_OUTSTANDING = 2,
    parameter int RESP_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic [3:0]  outstanding_o
);
    localparam int IW = $clog2(MEM_WORDS);
    localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int AW = $clog2(RESP_LATENCY + 1);
    localparam logic [31:0] SPAN = 32'(4 * MEM_WORDS);
    localparam logic [AW-1:0] LAT = AW'(RESP_LATENCY);
    localparam logic [3:0] MAXO = 4'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] LAST = PW'(MAX_OUTSTANDING - 1);

    logic [31:0]   mem [MEM_WORDS];
    logic [31:0]   q_rdata [MAX_OUTSTANDING];
    logic          q_err [MAX_OUTSTANDING];
    logic [AW-1:0] q_age [MAX_OUTSTANDING];
    logic [PW-1:0] head, tail;
    logic [3:0]    count;
    logic [31:0]   offs;
    logic [IW-1:0] idx;
    logic          acc_err, accept, pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == LAST ? '0 : p + PW'(1);
    endfunction

    // Addresses below the base wrap to a huge offset, so one compare covers both bounds.
    assign offs          = addr_i - BASE_ADDR;
    assign idx           = offs[IW+1:2];
    assign acc_err       = (offs[1:0] != 2'b00) || (offs >= SPAN);
    assign gnt_o         = !stall_i && (count < MAXO);
    assign accept        = req_i && gnt_o;
    assign rvalid_o      = (count != '0) && (q_age[head] == LAT);
    assign pop           = rvalid_o;
    assign rdata_o       = rvalid_o ? q_rdata[head] : '0;
    assign err_o         = rvalid_o && q_err[head];
    assign outstanding_o = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
        end else if (accept && we_i && !acc_err) begin
            for (int b = 0; b < 4; b++)
                if (be_i[b]) mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
    end

    // A pushed entry is stored with age 1: it has already aged across its acceptance edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                q_rdata[i] <= '0;
                q_err[i]   <= 1'b0;
                q_age[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < MAX_OUTSTANDING; i++)
                if (q_age[i] != LAT) q_age[i] <= q_age[i] + AW'(1);
            if (accept) begin
                q_rdata[tail] <= (we_i || acc_err) ? '0 : mem[idx];
                q_err[tail]   <= acc_err;
                q_age[tail]   <= AW'(1);
                tail          <= nxt(tail);
            end
            if (pop) head <= nxt(head);
            count <= count + {3'b000, accept} - {3'b000, pop};
        end
    end
endmodule

// File: tb/tb_cv32e40s_obi_mem_responder.sv
// tb_cv32e40s_obi_mem_responder: two responders (latency 1 and 3) checked every cycle
// against a cycle-indexed acceptance history, plus directed literal cases.
module tb_cv32e40s_obi_mem_responder;
    localparam int W = 64;
    localparam int NC = 4096;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk, rst_n;
    logic        stall [2], req [2], we [2], gnt [2], rvalid [2], err [2];
    logic [31:0] addr [2], wdata [2], rdata [2];
    logic [3:0]  be [2], outs_o [2];

    cv32e40s_obi_mem_responder #(.BASE_ADDR(BASE), .MEM_WORDS(W), .MAX_OUTSTANDING(2), .RESP_LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall[0]), .req_i(req[0]), .gnt_o(gnt[0]),
        .addr_i(addr[0]), .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]),
        .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]), .outstanding_o(outs_o[0]));

    cv32e40s_obi_mem_responder #(.BASE_ADDR(BASE), .MEM_WORDS(W), .MAX_OUTSTANDING(2), .RESP_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .stall_i(stall[1]), .req_i(req[1]), .gnt_o(gnt[1]),
        .addr_i(addr[1]), .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]),
        .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]), .outstanding_o(outs_o[1]));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Model: what was accepted in each cycle; a response is due exactly lat cycles later.
    logic [31:0] mm [2][W];
    bit          av [2][NC], ae [2][NC];
    logic [31:0] ad [2][NC];
    bit          last_acc [2];
    int          cyc = 0, vfrom = 0, errors = 0, checks = 0;
    logic [7:0]  lim_gnt = 8'b1111_0011, lim_rv = 8'b1001_1000;

    function automatic int lat(input int u);
        return u == 0 ? 1 : 3;
    endfunction

    function automatic int outs(input int u, input int c);
        int n = 0;
        for (int t = c - lat(u); t < c; t++)
            if (t >= vfrom && t >= 0 && av[u][t]) n++;
        return n;
    endfunction

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            longint off;
            bit     e;
            int     idx;
            last_acc[u] = 0;
            if (!rst_n) begin
                for (int w = 0; w < W; w++) mm[u][w] = '0;
            end else if (req[u] && !stall[u] && outs(u, cyc) < 2 && cyc < NC) begin
                off = longint'({32'b0, addr[u]}) - longint'({32'b0, BASE});
                e = (addr[u][1:0] != 2'b00) || off < 0 || off >= 4 * W;
                av[u][cyc] = 1;
                ae[u][cyc] = e;
                ad[u][cyc] = '0;
                if (!e) begin
                    idx = int'(off / 4);
                    if (!we[u]) ad[u][cyc] = mm[u][idx];
                    else
                        for (int b = 0; b < 4; b++)
                            if (be[u][b]) mm[u][idx][8*b +: 8] = wdata[u][8*b +: 8];
                end
                last_acc[u] = 1;
            end
        end
        if (!rst_n) vfrom = cyc + 1;
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        int t, eo;
        bit ev, ee;
        logic [31:0] ed;
        forever begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                t  = cyc - lat(u);
                ev = rst_n && t >= vfrom && av[u][t];
                ed = ev ? ad[u][t] : '0;
                ee = ev && ae[u][t];
                eo = rst_n ? outs(u, cyc) : 0;
                chk($sformatf("m_gnt%0d", u), gnt[u], !stall[u] && eo < 2);
                chk($sformatf("m_rvalid%0d", u), rvalid[u], ev);
                chk($sformatf("m_rdata%0d", u), rdata[u], ed);
                chk($sformatf("m_err%0d", u), err[u], ee);
                chk($sformatf("m_outs%0d", u), outs_o[u], eo);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int u);
        req[u] = 0; we[u] = 0; addr[u] = '0; be[u] = '0; wdata[u] = '0;
    endtask

    // One transaction; verifies grant, exact latency and the response literally.
    task automatic xact(input int u, input bit w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, input logic [31:0] er, input bit ee, input string nm);
        int n;
        req[u] = 1; we[u] = w; addr[u] = a; be[u] = b; wdata[u] = d;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_acc[u] && n < 20);
        idle(u);
        chk({nm, "_acc"}, last_acc[u], 1);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (rvalid[u]) break;
            n++;
        end
        chk({nm, "_rvalid"}, rvalid[u], 1);
        chk({nm, "_lat"}, n, lat(u) - 1);
        chk({nm, "_rdata"}, rdata[u], er);
        chk({nm, "_err"}, err[u], ee);
    endtask

    initial begin
        int r;
        for (int u = 0; u < 2; u++) begin
            idle(u);
            stall[u] = 0;
        end
        rst_n = 0;
        fork monitor(); join_none
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("rst_gnt", gnt[0], 1);
        chk("rst_rvalid", rvalid[0], 0);
        chk("rst_rdata", rdata[0], 0);
        chk("rst_err", err[0], 0);
        chk("rst_outs", outs_o[0], 0);
        xact(0, 0, BASE + 32'h4, 4'hF, 0, 32'h0, 0, "rd_init");

        // write then read of the same word on consecutive cycles
        req[0] = 1; we[0] = 1; addr[0] = BASE + 32'h8; be[0] = 4'hF; wdata[0] = 32'hDEAD_BEEF;
        tick();
        we[0] = 0;
        chk("b2b_wr_acc", last_acc[0], 1);
        @(negedge clk);
        chk("b2b_wr_rvalid", rvalid[0], 1);
        chk("b2b_wr_rdata", rdata[0], 0);
        chk("b2b_wr_err", err[0], 0);
        chk("b2b_gnt", gnt[0], 1);
        tick();
        idle(0);
        chk("b2b_rd_acc", last_acc[0], 1);
        @(negedge clk);
        chk("b2b_rd_rvalid", rvalid[0], 1);
        chk("b2b_rd_rdata", rdata[0], 32'hDEAD_BEEF);
        chk("b2b_rd_err", err[0], 0);

        xact(0, 1, BASE + 32'h8, 4'b0101, 32'h1122_3344, 0, 0, "part_wr");
        xact(0, 0, BASE + 32'h8, 4'h0, 0, 32'hDE22_BE44, 0, "part_rd");
        xact(0, 1, BASE + 32'h8, 4'h0, 32'hFFFF_FFFF, 0, 0, "be0_wr");
        xact(0, 0, BASE + 32'h8, 4'hF, 0, 32'hDE22_BE44, 0, "be0_rd");
        xact(0, 0, BASE + 32'(4 * W), 4'hF, 0, 0, 1, "oor_rd");
        xact(0, 0, BASE + 32'h2, 4'hF, 0, 0, 1, "mis_rd");
        xact(0, 1, BASE + 32'(4 * W), 4'hF, 32'h5555_5555, 0, 1, "oor_wr");
        xact(0, 1, BASE + 32'h1, 4'hF, 32'h6666_6666, 0, 1, "mis_wr");
        xact(0, 0, BASE, 4'hF, 0, 0, 0, "w0_rd");

        // outstanding limit on the latency-3 responder, request held high
        tick();
        for (int k = 0; k < 8; k++) begin
            req[1] = k < 5;
            be[1] = 4'hF;
            we[1] = k < 2;
            addr[1] = k == 1 ? BASE + 32'h14 : BASE + 32'h10;
            wdata[1] = k == 0 ? 32'hA5A5_0F0F : 32'h1234_5678;
            @(negedge clk);
            chk($sformatf("lim_gnt_c%0d", k), gnt[1], lim_gnt[k]);
            chk($sformatf("lim_rv_c%0d", k), rvalid[1], lim_rv[k]);
            chk($sformatf("lim_outs_c%0d", k), outs_o[1], k == 0 ? 0 : (k == 2 || k == 3) ? 2 : 1);
            chk($sformatf("lim_rdata_c%0d", k), rdata[1], k == 7 ? 32'hA5A5_0F0F : 32'h0);
            tick();
        end
        idle(1);

        // reset with two responses in flight
        req[1] = 1; addr[1] = BASE + 32'h14;
        tick();
        addr[1] = BASE + 32'h10;
        tick();
        chk("rst_pre_outs", outs_o[1], 2);
        rst_n = 0;
        idle(1);
        for (int k = 2; k < 8; k++) begin
            if (k == 4) rst_n = 1;
            @(negedge clk);
            chk($sformatf("rst_rv_c%0d", k), rvalid[1], 0);
            chk($sformatf("rst_outs_c%0d", k), outs_o[1], 0);
            tick();
        end
        xact(1, 0, BASE + 32'h10, 4'hF, 0, 0, 0, "rst_rd10");
        xact(1, 0, BASE + 32'h14, 4'hF, 0, 0, 0, "rst_rd14");
        xact(0, 0, BASE + 32'h8, 4'hF, 0, 0, 0, "rst_rd8");

        // random traffic with back-pressure, checked by the monitor
        for (int i = 0; i < 1500; i++) begin
            tick();
            for (int u = 0; u < 2; u++) begin
                stall[u] = $urandom_range(0, 4) == 0;
                if (!req[u] || last_acc[u]) begin
                    req[u] = $urandom_range(0, 3) != 0;
                    we[u] = 1'($urandom_range(0, 1));
                    be[u] = 4'($urandom);
                    wdata[u] = $urandom;
                    r = $urandom_range(0, 9);
                    addr[u] = r == 0 ? BASE + 32'(4 * W) :
                              r == 1 ? 32'hFFFF_FFFC :
                              r == 2 ? BASE + (32'($urandom_range(0, 255)) | 32'h1) :
                              r == 3 ? BASE + 32'(4 * (W - 1)) :
                                       BASE + 32'(4 * $urandom_range(0, 7));
                end
            end
        end
        tick();
        for (int u = 0; u < 2; u++) begin
            idle(u);
            stall[u] = 0;
        end
        repeat (8) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
